// File: rtl/ariscv_aclk_pkg.sv
`default_nettype none
// ============================================================================
// Module     : ariscv_aclk_pkg
// Description: Shared types and helpers for the ariscv stage-clock sequencer.
//              aclk_seq_state_e : sequencer FSM encoding (IDLE/WAIT/FIRE)
//              idx_w(n)         : index width for n items, never below 1
// Revision   : 1.0 - initial release
// ============================================================================
package ariscv_aclk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FIRE = 2'd2
    } aclk_seq_state_e;

    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ariscv_aclk_dly_cnt.sv
`default_nettype none
// ============================================================================
// Module     : ariscv_aclk_dly_cnt
// Description: Loadable down-counter holding the matched delay of the stage
//              currently waiting. Saturates at zero.
// Ports      : clk, rst_sync    - clock / synchronous active-high reset
//              i_load           - load i_load_val (has priority over i_dec)
//              i_load_val       - value to load
//              i_dec            - decrement by one when non-zero
//              o_zero           - count is zero
// Revision   : 1.0 - initial release
// ============================================================================
module ariscv_aclk_dly_cnt #(
    parameter int DLY_NBW = 4
) (
    input  logic               clk,
    input  logic               rst_sync,
    input  logic               i_load,
    input  logic [DLY_NBW-1:0] i_load_val,
    input  logic               i_dec,
    output logic               o_zero
);

    logic [DLY_NBW-1:0] cnt_q;
    logic [DLY_NBW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/ariscv_aclk_seq.sv
`default_nettype none
// ============================================================================
// Module     : ariscv_aclk_seq
// Description: Synchronous stage-clock sequencer. Emits one-hot, single-cycle,
//              non-overlapping pulses o_aclk[0..NSTAGES-1] in order, each
//              stage preceded by a programmable matched delay and gated by a
//              per-stage stall.
// Ports      : clk, rst_sync  - clock / synchronous active-high reset
//              i_en           - run request (sampled in IDLE and FIRE only)
//              i_stall        - per-stage hold, only o_stage's bit matters
//              i_cfg_we/idx/dly - delay-register write port
//              o_aclk         - one-hot stage pulse
//              o_stage        - stage waiting / next to fire
//              o_busy         - FSM not idle
//              o_wrap         - pulse with the last stage's o_aclk
//              o_round_cnt    - completed rounds (ARISCV_ACLK_SEQ_CNT_EN only)
// Options    : `define ARISCV_ACLK_SEQ_CNT_EN adds the round counter.
// Revision   : 1.0 - initial release
// ============================================================================
module ariscv_aclk_seq
    import ariscv_aclk_pkg::*;
#(
    parameter  int NSTAGES     = 6,
    parameter  int DLY_NBW     = 4,
    parameter  int DLY_DEFAULT = 1,
    parameter  int CNT_NBW     = 8,
    localparam int IDXW        = idx_w(NSTAGES)
) (
    input  logic               clk,
    input  logic               rst_sync,
    input  logic               i_en,
    input  logic [NSTAGES-1:0] i_stall,
    input  logic               i_cfg_we,
    input  logic [IDXW-1:0]    i_cfg_idx,
    input  logic [DLY_NBW-1:0] i_cfg_dly,
    output logic [NSTAGES-1:0] o_aclk,
    output logic [IDXW-1:0]    o_stage,
`ifdef ARISCV_ACLK_SEQ_CNT_EN
    output logic [CNT_NBW-1:0] o_round_cnt,
`endif
    output logic               o_busy,
    output logic               o_wrap
);

    localparam logic [IDXW-1:0]    c_last_stage = IDXW'(NSTAGES - 1);
    localparam logic [NSTAGES-1:0] c_one_hot0   = NSTAGES'(1);

    aclk_seq_state_e    state_q, state_d;
    logic [IDXW-1:0]    stage_q, stage_d;
    logic [NSTAGES-1:0] aclk_q,  aclk_d;
    logic               wrap_q,  wrap_d;
    logic [DLY_NBW-1:0] dly_q [NSTAGES];
    logic [DLY_NBW-1:0] dly_d [NSTAGES];

    logic               w_cnt_load;
    logic [DLY_NBW-1:0] w_cnt_load_val;
    logic               w_cnt_dec;
    logic               w_cnt_zero;
    logic [IDXW-1:0]    w_next_stage;

    assign w_next_stage = (stage_q == c_last_stage) ? '0 : stage_q + 1'b1;

    // Delay registers. Out-of-range indices match no entry and are dropped.
    // The counter loads from dly_q, so a same-cycle write is seen only by
    // the following load.
    always_comb begin
        for (int s = 0; s < NSTAGES; s++) begin
            dly_d[s] = dly_q[s];
            if (i_cfg_we && (i_cfg_idx == IDXW'(s))) begin
                dly_d[s] = i_cfg_dly;
            end
        end
    end

    // o_aclk/o_wrap are registered decodes of the FIRE state, so the pulse
    // appears the cycle after FIRE, coincident with o_stage advancing.
    always_comb begin
        state_d        = state_q;
        stage_d        = stage_q;
        aclk_d         = '0;
        wrap_d         = 1'b0;
        w_cnt_load     = 1'b0;
        w_cnt_load_val = dly_q[stage_q];
        w_cnt_dec      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_en) begin
                    state_d    = WAIT;
                    w_cnt_load = 1'b1;
                end
            end
            WAIT: begin
                if (!w_cnt_zero) begin
                    w_cnt_dec = 1'b1;
                end else if (!i_stall[stage_q]) begin
                    state_d = FIRE;
                end
            end
            FIRE: begin
                aclk_d         = c_one_hot0 << stage_q;
                wrap_d         = (stage_q == c_last_stage);
                stage_d        = w_next_stage;
                w_cnt_load_val = dly_q[w_next_stage];
                if (i_en) begin
                    state_d    = WAIT;
                    w_cnt_load = 1'b1;
                end else begin
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q <= IDLE;
            stage_q <= '0;
            aclk_q  <= '0;
            wrap_q  <= 1'b0;
            for (int s = 0; s < NSTAGES; s++) begin
                dly_q[s] <= DLY_NBW'(DLY_DEFAULT);
            end
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            aclk_q  <= aclk_d;
            wrap_q  <= wrap_d;
            dly_q   <= dly_d;
        end
    end

    ariscv_aclk_dly_cnt #(
        .DLY_NBW    (DLY_NBW)
    ) u_dly_cnt (
        .clk        (clk),
        .rst_sync   (rst_sync),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

`ifdef ARISCV_ACLK_SEQ_CNT_EN
    logic [CNT_NBW-1:0] round_cnt_q, round_cnt_d;

    // Counts on the same edge that raises o_wrap; wraps modulo 2^CNT_NBW.
    always_comb begin
        round_cnt_d = round_cnt_q + CNT_NBW'(wrap_d);
    end

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            round_cnt_q <= '0;
        end else begin
            round_cnt_q <= round_cnt_d;
        end
    end

    assign o_round_cnt = round_cnt_q;
`endif

    assign o_aclk  = aclk_q;
    assign o_wrap  = wrap_q;
    assign o_stage = stage_q;
    assign o_busy  = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ariscv_aclk_seq.sv
`default_nettype none
// ============================================================================
// Module     : tb_ariscv_aclk_seq
// Description: Self-checking bench for ariscv_aclk_seq (NSTAGES=6,
//              DLY_DEFAULT=1). Pulse gaps are counted in falling edges since
//              the previous observation point.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_ariscv_aclk_seq;

    logic       clk = 1'b0;
    logic       rst_sync;
    logic       i_en;
    logic [5:0] i_stall;
    logic       i_cfg_we;
    logic [2:0] i_cfg_idx;
    logic [3:0] i_cfg_dly;
    logic [5:0] o_aclk;
    logic [2:0] o_stage;
    logic       o_busy;
    logic       o_wrap;
`ifdef ARISCV_ACLK_SEQ_CNT_EN
    logic [7:0] o_round_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ariscv_aclk_seq #(
        .NSTAGES     (6),
        .DLY_NBW     (4),
        .DLY_DEFAULT (1),
        .CNT_NBW     (8)
    ) dut (
        .clk         (clk),
        .rst_sync    (rst_sync),
        .i_en        (i_en),
        .i_stall     (i_stall),
        .i_cfg_we    (i_cfg_we),
        .i_cfg_idx   (i_cfg_idx),
        .i_cfg_dly   (i_cfg_dly),
        .o_aclk      (o_aclk),
        .o_stage     (o_stage),
`ifdef ARISCV_ACLK_SEQ_CNT_EN
        .o_round_cnt (o_round_cnt),
`endif
        .o_busy      (o_busy),
        .o_wrap      (o_wrap)
    );

    typedef struct {
        logic [5:0] aclk;
        int         gap;
        logic       wrap;
    } pulse_vec_t;

    pulse_vec_t t_run [12];
    pulse_vec_t t_dly [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Waits (bounded) for the next non-zero o_aclk sample.
    task automatic wait_pulse(output logic [5:0] a, output logic w, output int gap);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while ((o_aclk == 6'b0) && (gap < 40));
        a = o_aclk;
        w = o_wrap;
    endtask

    task automatic do_reset();
        rst_sync = 1'b1;
        i_en     = 1'b0;
        i_stall  = '0;
        i_cfg_we = 1'b0;
        repeat (2) @(negedge clk);
        rst_sync = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [3:0] val);
        i_cfg_we  = 1'b1;
        i_cfg_idx = idx;
        i_cfg_dly = val;
        @(negedge clk);
        i_cfg_we  = 1'b0;
    endtask

    task automatic run_table_run(input string nm);
        logic [5:0] a;
        logic       w;
        int         g;
        for (int i = 0; i < 12; i++) begin
            wait_pulse(a, w, g);
            chk({nm, " aclk"}, 32'(a), 32'(t_run[i].aclk));
            chk({nm, " gap"},  32'(g), 32'(t_run[i].gap));
            chk({nm, " wrap"}, 32'(w), 32'(t_run[i].wrap));
            chk({nm, " stage"}, 32'(o_stage), 32'((i + 1) % 6));
        end
    endtask

    initial begin
        logic [5:0] a;
        logic       w;
        int         g;
        logic       any_pulse;
        logic       busy_drop;

        // Two full rounds at default delay: first gap dly+3 from the drive
        // edge (dly+2 after the sampling edge), then dly+2 between pulses.
        t_run[0]  = '{6'b000001, 4, 1'b0};
        t_run[1]  = '{6'b000010, 3, 1'b0};
        t_run[2]  = '{6'b000100, 3, 1'b0};
        t_run[3]  = '{6'b001000, 3, 1'b0};
        t_run[4]  = '{6'b010000, 3, 1'b0};
        t_run[5]  = '{6'b100000, 3, 1'b1};
        t_run[6]  = '{6'b000001, 3, 1'b0};
        t_run[7]  = '{6'b000010, 3, 1'b0};
        t_run[8]  = '{6'b000100, 3, 1'b0};
        t_run[9]  = '{6'b001000, 3, 1'b0};
        t_run[10] = '{6'b010000, 3, 1'b0};
        t_run[11] = '{6'b100000, 3, 1'b1};
        // dly[2]=3 stretches the stage1->stage2 gap to 5.
        t_dly[0]  = '{6'b000001, 4, 1'b0};
        t_dly[1]  = '{6'b000010, 3, 1'b0};
        t_dly[2]  = '{6'b000100, 5, 1'b0};
        t_dly[3]  = '{6'b001000, 3, 1'b0};
        t_dly[4]  = '{6'b010000, 3, 1'b0};
        t_dly[5]  = '{6'b100000, 3, 1'b1};

        i_cfg_idx = '0;
        i_cfg_dly = '0;
        do_reset();

        // Reset state
        chk("rst aclk",  32'(o_aclk),  32'h0);
        chk("rst stage", 32'(o_stage), 32'h0);
        chk("rst busy",  32'(o_busy),  32'h0);
        chk("rst wrap",  32'(o_wrap),  32'h0);
`ifdef ARISCV_ACLK_SEQ_CNT_EN
        chk("rst round_cnt", 32'(o_round_cnt), 32'h0);
`endif

        // T1 basic run
        i_en = 1'b1;
        run_table_run("t1");

        // T2 per-stage delay
        do_reset();
        cfg_write(3'd2, 4'd3);
        i_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_pulse(a, w, g);
            chk("t2 aclk", 32'(a), 32'(t_dly[i].aclk));
            chk("t2 gap",  32'(g), 32'(t_dly[i].gap));
            chk("t2 wrap", 32'(w), 32'(t_dly[i].wrap));
        end

        // T3 stall at stage 3 (reset restores dly[2]=1)
        do_reset();
        i_en = 1'b1;
        for (int i = 0; i < 3; i++) wait_pulse(a, w, g);
        chk("t3 pre aclk", 32'(a), 32'h04);
        // Bits 0 and 5 belong to stages not waiting and must have no effect.
        i_stall   = 6'b101001;
        any_pulse = 1'b0;
        busy_drop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (o_aclk != 6'b0) any_pulse = 1'b1;
            if (!o_busy)        busy_drop = 1'b1;
        end
        i_stall = '0;
        chk("t3 no pulse while stalled", 32'(any_pulse), 32'h0);
        chk("t3 busy while stalled",     32'(busy_drop), 32'h0);
        wait_pulse(a, w, g);
        chk("t3 aclk", 32'(a), 32'h08);
        chk("t3 gap",  32'(g), 32'd2);

        // T4 stop during stage-4 WAIT, then resume
        i_en = 1'b0;
        wait_pulse(a, w, g);
        chk("t4 aclk",  32'(a), 32'h10);
        chk("t4 gap",   32'(g), 32'd3);
        chk("t4 busy",  32'(o_busy),  32'h0);
        chk("t4 stage", 32'(o_stage), 32'd5);
        any_pulse = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if ((o_aclk != 6'b0) || o_busy || (o_stage != 3'd5)) any_pulse = 1'b1;
        end
        chk("t4 idle hold", 32'(any_pulse), 32'h0);
        i_en = 1'b1;
        wait_pulse(a, w, g);
        chk("t4 resume aclk", 32'(a), 32'h20);
        chk("t4 resume gap",  32'(g), 32'd4);
        chk("t4 resume wrap", 32'(w), 32'h1);

        // T5 reset during the stage-0 FIRE cycle; dly[2] write must be undone
        cfg_write(3'd2, 4'd3);
        @(negedge clk);
        rst_sync = 1'b1;
        @(negedge clk);
        chk("t5 aclk",  32'(o_aclk),  32'h0);
        chk("t5 stage", 32'(o_stage), 32'h0);
        chk("t5 busy",  32'(o_busy),  32'h0);
        rst_sync = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_pulse(a, w, g);
            chk("t5 aclk", 32'(a), 32'(t_run[i].aclk));
            chk("t5 gap",  32'(g), 32'(t_run[i].gap));
        end

        // T6 out-of-range config index, two rounds
        do_reset();
        cfg_write(3'd7, 4'd9);
        i_en = 1'b1;
        run_table_run("t6");
`ifdef ARISCV_ACLK_SEQ_CNT_EN
        chk("t6 round_cnt", 32'(o_round_cnt), 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
